fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter plus opcode/immediate registers feeding the mcu FSM and the datapath.
//  Drives the program-ROM address and captures ROM words as either opcode or immediate.
//  Acts on mcu strobes: pc_count, pc_load, opcode_update, imm_update.
//  Checks the opcode/immediate strobe sequence, counts fetched instructions and flags PC wrap-around.
// PARAMETERS
//  ADDR_WIDTH  8   program-ROM address / PC width
//  DATA_WIDTH  8   program-ROM word width; also the imm width
//  OP_WIDTH    5   opcode width, taken from prog_data[OP_WIDTH-1:0]
//  CNT_WIDTH   16  instruction counter width
// PORTS
//  clk            in   1           system clock, all state on rising edge
//  rst            in   1           asynchronous reset, active high
//  pc_count       in   1           PC increment strobe (mcu)
//  pc_load        in   1           PC load-from-imm strobe (mcu)
//  opcode_update  in   1           capture opcode from prog_data (mcu)
//  imm_update     in   1           capture immediate from prog_data (mcu)
//  err_clr        in   1           clears seq_err and pc_wrap
//  prog_data      in   DATA_WIDTH  program-ROM read data (combinational w.r.t. prog_addr)
//  prog_addr      out  ADDR_WIDTH  program-ROM address = current PC
//  opcode         out  OP_WIDTH    registered opcode, to mcu
//  imm            out  DATA_WIDTH  registered immediate, to datapath/RAM address
//  inst_count     out  CNT_WIDTH   number of opcode captures, saturating
//  seq_err        out  1           sticky strobe-sequence error
//  pc_wrap        out  1           sticky: PC incremented from all-ones to 0
// BEHAVIOUR
//  Reset (async, rst=1): pc=0, opcode=0, imm=0, inst_count=0, seq_err=0, pc_wrap=0, chk state=EXP_OPC.
//  Reset mid-operation discards any pending capture/increment; the first edge after rst release acts normally.
//  prog_addr = pc (no extra latency). A strobe at edge N is visible at outputs after edge N.
//  PC update, priority order:
//   pc_load=1 -> pc <= imm[ADDR_WIDTH-1:0] (zero-extend if DATA_WIDTH<ADDR_WIDTH); pc_count ignored.
//   else pc_count=1 -> pc <= pc+1 mod 2^ADDR_WIDTH; if pc was all-ones, set pc_wrap.
//   else pc holds.
//  pc_load uses the imm value registered before the edge, never the one captured at the same edge.
//  opcode_update=1 -> opcode <= prog_data[OP_WIDTH-1:0], sampled at the pre-update prog_addr.
//  imm_update=1 -> imm <= prog_data.
//  inst_count: +1 on each opcode_update edge; holds at all-ones (no wrap).
//  Sequence checker FSM, states EXP_OPC and EXP_IMM:
//   EXP_OPC: opcode_update alone -> EXP_IMM; imm_update -> set seq_err, stay.
//   EXP_IMM: imm_update alone -> EXP_OPC; opcode_update -> set seq_err, stay.
//   opcode_update and imm_update together in either state -> set seq_err, state unchanged.
//   Captures still happen on erroneous strobes; the checker only flags.
//  err_clr=1 clears seq_err and pc_wrap. A set condition at the same edge wins (flag stays 1).
//  Expected mcu cadence: reset/execute (count+opc), fetch (imm), decode (count[, load]), 2 words per instr.
// CONFIGURATION
//  FETCH_BRANCH_TRACE_EN defined: adds a 4-entry circular trace buffer.
//   Adds ports trace_idx in [1:0] and trace_pc out ADDR_WIDTH.
//   Each pc_load edge writes the pre-load pc at the write pointer, then wptr++ (mod 4, overwrite oldest).
//   trace_pc = entry[(wptr-1-trace_idx) mod 4], combinational; idx 0 = most recent.
//   Reset clears all entries and wptr to 0.
//  FETCH_BRANCH_TRACE_EN undefined: no trace logic and no trace ports.
// TESTING
//  Reset, ROM[0]=0x03, ROM[1]=0x2A; drive mcu cadence -> opcode=0x03, imm=0x2A, pc=2, inst_count=1, seq_err=0.
//  imm=0x10, assert pc_load+pc_count together -> pc=0x10 (load wins); with trace, trace_pc(idx0)=pre-load pc.
//  pc=0xFF, pc_count -> pc=0x00, pc_wrap=1; err_clr -> pc_wrap=0.
//  Two opcode_update with no imm_update between -> seq_err=1 after 2nd; err_clr -> 0; checker stays EXP_IMM.
//  rst pulse mid-decode with pc=0x05 -> all outputs 0 immediately (async), next opcode captured from ROM[0].
//  Trace: 5 jumps from pcs 1,3,5,7,9 -> trace_pc idx0..3 = 9,7,5,3 (oldest overwritten).

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, opcode/immediate capture, strobe-sequence checker and instruction counter (optional branch trace via FETCH_BRANCH_TRACE_EN)
module fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_count,
  input  logic                  pc_load,
  input  logic                  opcode_update,
  input  logic                  imm_update,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [OP_WIDTH-1:0]   opcode,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [CNT_WIDTH-1:0]  inst_count,
  output logic                  seq_err,
`ifdef FETCH_BRANCH_TRACE_EN
  output logic                  pc_wrap,
  input  logic [1:0]            trace_idx,
  output logic [ADDR_WIDTH-1:0] trace_pc
`else
  output logic                  pc_wrap
`endif
);
  typedef enum logic {EXP_OPC, EXP_IMM} chk_t;
  chk_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [OP_WIDTH-1:0]   opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  seq_err_q, seq_err_d, pc_wrap_q, pc_wrap_d;
  logic                  seq_set, wrap_set;
  // checker state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= EXP_OPC;
    else     state_q <= state_d;
  // checker next state: simultaneous strobes never advance the state
  always_comb
    state_d = (opcode_update && imm_update) ? state_q :
              (state_q == EXP_OPC) ? (opcode_update ? EXP_IMM : EXP_OPC) :
              (imm_update ? EXP_OPC : EXP_IMM);
  // checker output: flag a strobe arriving out of order or both at once
  always_comb
    seq_set = (opcode_update && imm_update) ||
              (state_q == EXP_OPC && imm_update) ||
              (state_q == EXP_IMM && opcode_update);
  // datapath next values; load beats count and uses the already-registered imm
  always_comb begin
    wrap_set  = !pc_load && pc_count && (&pc_q);
    pc_d      = pc_load ? ADDR_WIDTH'(imm_q) : pc_count ? pc_q + ADDR_WIDTH'(1) : pc_q;
    opcode_d  = opcode_update ? prog_data[OP_WIDTH-1:0] : opcode_q;
    imm_d     = imm_update ? prog_data : imm_q;
    cnt_d     = (opcode_update && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    seq_err_d = seq_set || (seq_err_q && !err_clr);
    pc_wrap_d = wrap_set || (pc_wrap_q && !err_clr);
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q      <= '0;
      opcode_q  <= '0;
      imm_q     <= '0;
      cnt_q     <= '0;
      seq_err_q <= 1'b0;
      pc_wrap_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      imm_q     <= imm_d;
      cnt_q     <= cnt_d;
      seq_err_q <= seq_err_d;
      pc_wrap_q <= pc_wrap_d;
    end
  assign prog_addr  = pc_q;
  assign opcode     = opcode_q;
  assign imm        = imm_q;
  assign inst_count = cnt_q;
  assign seq_err    = seq_err_q;
  assign pc_wrap    = pc_wrap_q;
`ifdef FETCH_BRANCH_TRACE_EN
  logic [ADDR_WIDTH-1:0] tr_q [4];
  logic [ADDR_WIDTH-1:0] tr_d [4];
  logic [1:0]            wptr_q, wptr_d;
  // trace write: record the pc being jumped away from, overwriting the oldest entry
  always_comb begin
    tr_d = tr_q;
    if (pc_load) tr_d[wptr_q] = pc_q;
    wptr_d = wptr_q + 2'(pc_load);
  end
  // trace registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tr_q   <= '{default: '0};
      wptr_q <= '0;
    end else begin
      tr_q   <= tr_d;
      wptr_q <= wptr_d;
    end
  assign trace_pc = tr_q[wptr_q - 2'd1 - trace_idx];
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and random strobes against a behavioural model
module tb_fetch_unit;
  logic        clk = 0, rst = 1;
  logic        pc_count = 0, pc_load = 0, opcode_update = 0, imm_update = 0, err_clr = 0;
  logic [7:0]  prog_data, prog_addr, imm;
  logic [4:0]  opcode;
  logic [15:0] inst_count;
  logic        seq_err, pc_wrap;
  logic [7:0]  rom [256];
  int          n_chk = 0, n_fail = 0;
`ifdef FETCH_BRANCH_TRACE_EN
  logic [1:0]  trace_idx = 0;
  logic [7:0]  trace_pc;
`endif

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_count(pc_count), .pc_load(pc_load),
    .opcode_update(opcode_update), .imm_update(imm_update), .err_clr(err_clr),
    .prog_data(prog_data), .prog_addr(prog_addr), .opcode(opcode), .imm(imm),
    .inst_count(inst_count), .seq_err(seq_err),
`ifdef FETCH_BRANCH_TRACE_EN
    .trace_idx(trace_idx), .trace_pc(trace_pc),
`endif
    .pc_wrap(pc_wrap)
  );

  assign prog_data = rom[prog_addr];
  always #5 clk = ~clk;

  int m_pc, m_op, m_imm, m_cnt, m_err, m_wrap, m_wait;
  int m_tr[$];

  function automatic void m_reset();
    m_pc = 0; m_op = 0; m_imm = 0; m_cnt = 0; m_err = 0; m_wrap = 0; m_wait = 0;
    m_tr.delete();
  endfunction

  function automatic void m_step(bit c, bit l, bit o, bit i, bit e);
    int d;
    bit es, ws;
    d  = rom[m_pc];
    es = (o && i) || (i && m_wait == 0) || (o && m_wait == 1);
    if (!(o && i)) m_wait = o ? 1 : i ? 0 : m_wait;
    ws = !l && c && m_pc == 255;
    if (l) m_tr.push_back(m_pc);
    m_pc = l ? m_imm : c ? (m_pc + 1) % 256 : m_pc;
    if (o) m_op = d % 32;
    if (i) m_imm = d;
    if (o && m_cnt < 65535) m_cnt++;
    m_err  = (es || (m_err  != 0 && !e)) ? 1 : 0;
    m_wrap = (ws || (m_wrap != 0 && !e)) ? 1 : 0;
  endfunction

  function automatic int m_trace(int k);
    return (k < m_tr.size()) ? m_tr[m_tr.size() - 1 - k] : 0;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("prog_addr", int'(prog_addr), m_pc);
    chk("opcode", int'(opcode), m_op);
    chk("imm", int'(imm), m_imm);
    chk("inst_count", int'(inst_count), m_cnt);
    chk("seq_err", int'(seq_err), m_err);
    chk("pc_wrap", int'(pc_wrap), m_wrap);
`ifdef FETCH_BRANCH_TRACE_EN
    chk("trace_pc0", int'(trace_pc), m_trace(0));
`endif
  endtask

  task automatic step(input bit c, input bit l, input bit o, input bit i, input bit e);
    pc_count = c; pc_load = l; opcode_update = o; imm_update = i; err_clr = e;
    @(posedge clk);
    m_step(c, l, o, i, e);
    #1;
    pc_count = 0; pc_load = 0; opcode_update = 0; imm_update = 0; err_clr = 0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1;
    m_reset();
    #1 check_all();
    @(posedge clk);
    #1 rst = 0;
  endtask

  typedef struct {
    bit c, l, o, i, e;
    int pc, op, im, cnt, err, wrap;
  } vec_t;
  vec_t tbl[6];

  initial begin
    for (int k = 0; k < 256; k++) rom[k] = 8'($urandom);
    rom[0] = 8'h03; rom[1] = 8'h2A; rom[2] = 8'hE5; rom[3] = 8'h10;
    rom[8'h10] = 8'h07; rom[8'h11] = 8'hFF;
    tbl[0] = '{1, 0, 1, 0, 0, 8'h01, 8'h03, 8'h00, 1, 0, 0};
    tbl[1] = '{0, 0, 0, 1, 0, 8'h01, 8'h03, 8'h2A, 1, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 0, 8'h02, 8'h03, 8'h2A, 1, 0, 0};
    tbl[3] = '{1, 0, 1, 0, 0, 8'h03, 8'h05, 8'h2A, 2, 0, 0};
    tbl[4] = '{0, 0, 0, 1, 0, 8'h03, 8'h05, 8'h10, 2, 0, 0};
    tbl[5] = '{1, 1, 0, 0, 0, 8'h10, 8'h05, 8'h10, 2, 0, 0};
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      step(tbl[k].c, tbl[k].l, tbl[k].o, tbl[k].i, tbl[k].e);
      chk("tbl_pc", int'(prog_addr), tbl[k].pc);
      chk("tbl_opcode", int'(opcode), tbl[k].op);
      chk("tbl_imm", int'(imm), tbl[k].im);
      chk("tbl_cnt", int'(inst_count), tbl[k].cnt);
      chk("tbl_seq_err", int'(seq_err), tbl[k].err);
      chk("tbl_pc_wrap", int'(pc_wrap), tbl[k].wrap);
    end
`ifdef FETCH_BRANCH_TRACE_EN
    chk("tbl_trace_preload", int'(trace_pc), 8'h03);
`endif
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    chk("load_to_ff", int'(prog_addr), 8'hFF);
    chk("no_wrap_on_load", int'(pc_wrap), 0);
    step(1, 0, 0, 0, 0);
    chk("wrap_pc", int'(prog_addr), 0);
    chk("wrap_set", int'(pc_wrap), 1);
    step(0, 0, 0, 0, 1);
    chk("wrap_clr", int'(pc_wrap), 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("load_ff_with_count", int'(pc_wrap), 0);
    step(1, 0, 0, 0, 1);
    chk("wrap_set_beats_clr", int'(pc_wrap), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    chk("seq_ok_first_opc", int'(seq_err), 0);
    step(0, 0, 1, 0, 0);
    chk("seq_double_opc", int'(seq_err), 1);
    step(0, 0, 0, 0, 1);
    chk("seq_clr", int'(seq_err), 0);
    step(0, 0, 0, 1, 0);
    chk("seq_still_exp_imm", int'(seq_err), 0);
    step(0, 0, 1, 1, 0);
    chk("seq_both", int'(seq_err), 1);
    for (int k = 0; k < 500; k++)
      step(1'($urandom), ($urandom % 5) == 0, 1'($urandom), 1'($urandom), ($urandom % 8) == 0);
    do_reset();
    rom[0] = 8'h1C; rom[1] = 8'h41; rom[4] = 8'h09; rom[5] = 8'h77;
    step(1, 0, 1, 0, 0); step(0, 0, 0, 1, 0); step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0); step(0, 0, 0, 1, 0); step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0); step(0, 0, 0, 1, 0);
    chk("pre_rst_pc", int'(prog_addr), 5);
    pc_count = 1; pc_load = 1;
    #3 rst = 1;
    m_reset();
    #1 check_all();
    @(posedge clk);
    #1 rst = 0; pc_count = 0; pc_load = 0;
    check_all();
    step(1, 0, 1, 0, 0);
    chk("opc_after_rst", int'(opcode), 8'h1C);
`ifdef FETCH_BRANCH_TRACE_EN
    do_reset();
    rom[1] = 3; rom[3] = 5; rom[5] = 7; rom[7] = 9; rom[9] = 8'h20;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      trace_idx = 2'(k);
      #1 chk("trace_idx", int'(trace_pc), 9 - 2 * k);
    end
    trace_idx = 0;
`endif
    do_reset();
    for (int k = 0; k < 65540; k++) begin
      opcode_update = 1;
      @(posedge clk);
      m_step(0, 0, 1, 0, 0);
    end
    #1 opcode_update = 0;
    check_all();
    chk("cnt_saturate", int'(inst_count), 16'hFFFF);
    step(0, 0, 1, 0, 0);
    chk("cnt_hold", int'(inst_count), 16'hFFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
